// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Brief    : VGA timing generator with horizontal/vertical counters,
//             registered sync/active flags and line/frame start pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] count_rgb,
  output logic [9:0]  reset_count_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] C_H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  C_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  C_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  C_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        act_q, act_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic [7:0]  fc_q, fc_d;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_in_hs;
  logic w_in_vs;

  // Wrap on >= so an out-of-range count can never persist.
  assign w_h_wrap = (h_q >= C_H_LAST);
  assign w_v_wrap = (v_q >= C_V_LAST);
  assign w_in_hs  = (h_q >= C_HS_START) && (h_q <= C_HS_END);
  assign w_in_vs  = (v_q >= C_VS_START) && (v_q <= C_VS_END);

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    act_d = act_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    fc_d  = fc_q;
    if (en) begin
      h_d = w_h_wrap ? 11'd0 : h_q + 11'd1;
      if (w_h_wrap) begin
        v_d = w_v_wrap ? 10'd0 : v_q + 10'd1;
      end
      if (w_h_wrap && w_v_wrap) begin
        fc_d = fc_q + 8'd1;
      end
      // Flags are decoded from the pre-edge count, giving a 1-clock lag.
      hs_d  = w_in_hs ? SYNC_POL : ~SYNC_POL;
      vs_d  = w_in_vs ? SYNC_POL : ~SYNC_POL;
      act_d = (h_q < C_H_ACT) && (v_q < C_V_ACT);
      ls_d  = (h_q == 11'd0);
      fs_d  = (h_q == 11'd0) && (v_q == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= 11'd0;
      v_q   <= 10'd0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= 8'd0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
    end
  end

  assign count_rgb       = h_q;
  assign reset_count_rgb = v_q;
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign active          = act_q;
  assign line_start      = ls_q;
  assign frame_start     = fs_q;
  assign frame_cnt       = fc_q;

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 40, meaning horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 128, meaning hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BP, default 88, meaning horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 600, meaning visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 1, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 4, meaning vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 23, meaning vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 1, meaning asserted level of hsync/vsync.
REQ-010 SHALL have port clk, input, 1, the single pixel clock (40 MHz for defaults).
REQ-011 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-012 SHALL have port en, input, 1, advance enable.
REQ-013 SHALL have port count_rgb, output, 11, horizontal pixel counter.
REQ-014 SHALL have port reset_count_rgb, output, 10, vertical line counter.
REQ-015 SHALL have port hsync, output, 1, horizontal sync, registered.
REQ-016 SHALL have port vsync, output, 1, vertical sync, registered.
REQ-017 SHALL have port active, output, 1, registered visible-area flag.
REQ-018 SHALL have port line_start, output, 1, one-clock pulse at the start of each line.
REQ-019 SHALL have port frame_start, output, 1, one-clock pulse at the start of each frame.
REQ-020 SHALL have port frame_cnt, output, 8, count of completed frames.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
REQ-022 On each clk rising edge with en=1, count_rgb SHALL increment by 1 and wrap from H_TOTAL-1 to 0.
REQ-023 reset_count_rgb SHALL increment only on the edge where count_rgb wraps; it wraps from V_TOTAL-1 to 0 on the same edge where both counters wrap.
REQ-024 count_rgb and reset_count_rgb SHALL never exceed 1055 and 627 respectively.
REQ-025 hsync SHALL take the value SYNC_POL on the edge after count_rgb is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (840..967); otherwise it takes ~SYNC_POL.
REQ-026 vsync SHALL take the value SYNC_POL on the edge after reset_count_rgb is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (601..604); otherwise it takes ~SYNC_POL.
REQ-027 active SHALL be registered from (count_rgb<H_ACTIVE && reset_count_rgb<V_ACTIVE).
REQ-028 hsync, vsync and active therefore lag the counters by exactly 1 clock, matching the 1-clock latency of the downstream pixel fetch stage.
REQ-029 line_start SHALL be 1 for exactly one clock, on the clock after count_rgb==0 is sampled with en=1.
REQ-030 frame_start SHALL be 1 for exactly one clock, on the clock after count_rgb==0 and reset_count_rgb==0 are sampled with en=1.
REQ-031 frame_cnt SHALL increment by 1 (mod 256, 255->0) on the edge where both counters wrap to 0.
REQ-032 With en=0, counters, hsync, vsync, active and frame_cnt SHALL hold their values, and line_start and frame_start SHALL be 0.
REQ-033 When en rises, counting SHALL resume from the held values with no skipped or repeated count.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for clk, force count_rgb=0, reset_count_rgb=0, hsync=~SYNC_POL, vsync=~SYNC_POL, active=0, line_start=0, frame_start=0 and frame_cnt=0.
REQ-035 Reset asserted mid-line or mid-frame SHALL abort the frame; after release, the first enabled edge produces count_rgb=1 and line_start=frame_start=1.

Verification
REQ-036 Release reset with en=1 and run 1056 clocks -> count_rgb sequence 0..1055,0; hsync=1 for exactly 128 clocks, beginning the clock after count_rgb=840.
REQ-037 Run one full frame (663168 clocks) -> vsync=1 for 4 lines, beginning after reset_count_rgb=601; frame_start pulses once; frame_cnt 0->1; active high for 480000 clocks.
REQ-038 Assert rst_n=0 asynchronously between edges at count_rgb=500, reset_count_rgb=300 -> all outputs take their reset values before the next edge.
REQ-039 Hold en=0 for 10 clocks at count_rgb=839 -> counters hold at 839, hsync stays 0 and no pulses occur; after en=1, count_rgb=840 and hsync=1 one clock later.
REQ-040 Run 256 frames -> frame_cnt wraps 255->0 on the edge where count_rgb and reset_count_rgb both wrap.
REQ-041 With SYNC_POL=0 -> hsync and vsync are 1 at reset and 0 only in the sync windows.
